// File: rtl/cpu_fifo_reader.sv
// Receiving end of the CPU FIFO push-stream: skid-buffered words re-exposed
// through a pull interface, with registered backpressure and sticky overflow.
module cpu_fifo_reader #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 4,
  parameter int unsigned skid  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [width-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_full,
  input  logic                     flush,
  input  logic                     read_req,
  output logic [width-1:0]         read_data,
  output logic                     read_valid,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  // Threshold leaves room for the words upstream may still have in flight.
  localparam logic [CW-1:0] FULL_AT = CW'(depth - skid);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    count_next;

  // A pop at the same edge frees the slot, so a push into a full buffer is legal then.
  always_comb begin
    pop_ok     = read_req && (count != '0);
    push_ok    = in_valid && ((count != DEPTH_C) || pop_ok);
    count_next = count + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset && !flush && push_ok)
      mem[tail] <= in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      in_full    <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      in_full    <= 1'b0;
      read_valid <= 1'b0;
    end else begin
      if (push_ok)
        tail <= tail + 1'b1;
      if (pop_ok) begin
        read_data <= mem[head];
        head      <= head + 1'b1;
      end
      read_valid <= pop_ok;
      if (in_valid && !push_ok)
        overflow <= 1'b1;
      count   <= count_next;
      in_full <= (count_next >= FULL_AT);
    end
  end

endmodule

// File: tb/tb_cpu_fifo_reader.sv
// Bench for cpu_fifo_reader: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cpu_fifo_reader;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
  localparam int unsigned S = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_full;
  logic          flush = 1'b0;
  logic          read_req = 1'b0;
  logic [W-1:0]  read_data;
  logic          read_valid;
  logic [2:0]    count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  cpu_fifo_reader #(.width(W), .depth(D), .skid(S)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_full(in_full), .flush(flush), .read_req(read_req),
    .read_data(read_data), .read_valid(read_valid), .count(count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Reference model: a plain queue holding the buffered words.
  logic [W-1:0] q[$];
  logic         m_full = 1'b0;
  logic         m_rv = 1'b0;
  logic [W-1:0] m_rd = '0;
  logic         m_ovf = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_full = 1'b0; m_rv = 1'b0; m_rd = '0; m_ovf = 1'b0;
    end else if (flush) begin
      q.delete();
      m_full = 1'b0; m_rv = 1'b0;
    end else begin
      int n;
      bit do_pop, do_push;
      n = q.size();
      do_pop  = read_req && (n > 0);
      do_push = in_valid && ((n < int'(D)) || do_pop);
      if (do_pop) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (in_valid && !do_push) m_ovf = 1'b1;
      if (do_push) q.push_back(in_data);
      m_full = (q.size() >= int'(D - S));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("model_count", 64'(count), 64'(q.size()));
    check("model_in_full", 64'(in_full), 64'(m_full));
    check("model_read_valid", 64'(read_valid), 64'(m_rv));
    check("model_read_data", 64'(read_data), 64'(m_rd));
    check("model_overflow", 64'(overflow), 64'(m_ovf));
  end

  task automatic step(input logic iv, input logic [W-1:0] d, input logic rr, input logic fl);
    in_valid = iv; in_data = d; read_req = rr; flush = fl;
    @(posedge clock);
    #1;
    in_valid = 1'b0; read_req = 1'b0; flush = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [W-1:0] exp);
    step(1'b0, '0, 1'b1, 1'b0);
    check({name, "_rv"}, 64'(read_valid), 64'd1);
    check({name, "_rd"}, 64'(read_data), 64'(exp));
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check("reset_count", 64'(count), 64'd0);
    check("reset_rd", 64'(read_data), 64'd0);

    // Ordered transfer
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    check("ord_count3", 64'(count), 64'd3);
    pop_expect("ord0", 32'h11);
    pop_expect("ord1", 32'h22);
    pop_expect("ord2", 32'h33);
    check("ord_count0", 64'(count), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("empty_pop_rv", 64'(read_valid), 64'd0);
    check("empty_pop_hold", 64'(read_data), 64'h33);

    // Backpressure with skid
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    check("bp_full1", 64'(in_full), 64'd0);
    step(1'b1, 32'hA2, 1'b0, 1'b0);
    check("bp_full2", 64'(in_full), 64'd0);
    step(1'b1, 32'hA3, 1'b0, 1'b0);
    check("bp_full3", 64'(in_full), 64'd1);
    step(1'b1, 32'hA4, 1'b0, 1'b0);
    check("bp_count4", 64'(count), 64'd4);
    check("bp_ovf", 64'(overflow), 64'd0);

    // Simultaneous push and pop at full
    step(1'b1, 32'hAA, 1'b1, 1'b0);
    check("sim_count", 64'(count), 64'd4);
    check("sim_ovf", 64'(overflow), 64'd0);
    check("sim_rd", 64'(read_data), 64'hA1);
    pop_expect("sim0", 32'hA2);
    pop_expect("sim1", 32'hA3);
    pop_expect("sim2", 32'hA4);
    pop_expect("sim3", 32'hAA);

    // Overflow
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hBF, 1'b0, 1'b0);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) pop_expect("ovf_pop", 32'hB0 + 32'(i));
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Wrap: each push overlaps the pop of the previous word
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hC0 + 32'(i), (i > 0), 1'b0);
      if (i > 0) check("wrap_rd", 64'(read_data), 64'(32'hC0 + 32'(i - 1)));
    end
    pop_expect("wrap_last", 32'hC9);

    // Flush with an arriving word
    step(1'b1, 32'hD0, 1'b0, 1'b0);
    step(1'b1, 32'hD1, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_full", 64'(in_full), 64'd0);
    check("flush_rv", 64'(read_valid), 64'd0);
    check("flush_ovf", 64'(overflow), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_nopop", 64'(read_valid), 64'd0);

    // Asynchronous reset mid-stream
    step(1'b1, 32'hE0, 1'b0, 1'b0);
    step(1'b1, 32'hE1, 1'b0, 1'b0);
    step(1'b1, 32'hE2, 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd3);
    #2 reset = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(in_full), 64'd0);
    check("rst_rv", 64'(read_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_rv", 64'(read_valid), 64'd0);
    check("post_rst_count", 64'(count), 64'd0);

    repeat (2) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
